// File: rtl/game_pkg.sv
// Shared game-state types and default constants for the enemy status controller.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StL1Init,
    StL1Play,
    StL2Init,
    StL2Play,
    StL3Init,
    StL3Play,
    StWon
  } game_state_t;

  localparam logic [7:0] DEF_START_KEY = 8'h28;

  // Off-screen position Monster uses for dead or undrawn enemies.
  localparam logic [9:0] PARK_X = 10'd700;
  localparam logic [9:0] PARK_Y = 10'd520;

  localparam logic [9:0]  DEF_MON_R   = 10'd25;
  localparam logic [9:0]  DEF_MON3_R  = 10'd15;
  localparam logic [9:0]  DEF_BOSS_R  = 10'd30;
  localparam int unsigned DEF_BOSS_HP = 5;

  function automatic logic is_init(game_state_t s);
    return (s == StL1Init) || (s == StL2Init) || (s == StL3Init);
  endfunction

endpackage

// File: rtl/enemy_status_ctrl_if.sv
// Frame-rate bus between keyboard/missile/Monster blocks and the enemy status controller.
interface enemy_status_if;
  import game_pkg::*;

  logic [7:0] keycode;
  logic       missile_active;
  logic [9:0] MissileX;
  logic [9:0] MissileY;
  logic [9:0] MonsterX;
  logic [9:0] MonsterY;
  logic [9:0] MonsterX2;
  logic [9:0] MonsterY2;
  logic [9:0] MonsterX3;
  logic [9:0] MonsterY3;
  logic [9:0] BossX;
  logic [9:0] BossY;

  logic is_dead;
  logic is_dead2;
  logic is_dead3;
  logic boss_dead;
  logic draw_level1;
  logic draw_level2;
  logic draw_level3;
  logic set_motion_1;
  logic set_motion_2;
  logic set_motion_3;
  logic missile_hit;
  logic game_won;

  // Game/position side: drives positions and keys, consumes status.
  modport master (
    output keycode, missile_active, MissileX, MissileY,
    output MonsterX, MonsterY, MonsterX2, MonsterY2, MonsterX3, MonsterY3, BossX, BossY,
    input  is_dead, is_dead2, is_dead3, boss_dead,
    input  draw_level1, draw_level2, draw_level3,
    input  set_motion_1, set_motion_2, set_motion_3,
    input  missile_hit, game_won
  );

  // Controller side.
  modport slave (
    input  keycode, missile_active, MissileX, MissileY,
    input  MonsterX, MonsterY, MonsterX2, MonsterY2, MonsterX3, MonsterY3, BossX, BossY,
    output is_dead, is_dead2, is_dead3, boss_dead,
    output draw_level1, draw_level2, draw_level3,
    output set_motion_1, set_motion_2, set_motion_3,
    output missile_hit, game_won
  );

endinterface

// File: rtl/hit_box.sv
// Square overlap test: both axis distances within radius (inclusive).
module hit_box (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic [9:0] radius,
  output logic       overlap
);

  logic [9:0] dx;
  logic [9:0] dy;

  // Larger minus smaller keeps the magnitude in 10 bits without a sign bit.
  always_comb begin
    dx      = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy      = (ay >= by) ? (ay - by) : (by - ay);
    overlap = (dx <= radius) && (dy <= radius);
  end

endmodule

// File: rtl/enemy_status_ctrl.sv
// Level sequencer and missile hit resolver feeding the Monster motion block.
module enemy_status_ctrl import game_pkg::*; #(
  parameter logic [7:0]  START_KEY = DEF_START_KEY,
  parameter logic [9:0]  MON_R     = DEF_MON_R,
  parameter logic [9:0]  MON3_R    = DEF_MON3_R,
  parameter logic [9:0]  BOSS_R    = DEF_BOSS_R,
  parameter int unsigned BOSS_HP   = DEF_BOSS_HP
) (
  input  logic           frame_clk,
  input  logic           Reset,
  enemy_status_if.slave  bus
);

  localparam logic [2:0] BossHpInit = 3'(BOSS_HP);

  game_state_t state_q, state_d;
  logic [3:0]  dead_q, dead_d;      // {boss, monster3, monster2, monster1}
  logic [2:0]  boss_hp_q, boss_hp_d;
  logic        hit_q, hit_d;
  logic [2:0]  draw_q, draw_d;
  logic [2:0]  motion_q, motion_d;
  logic        won_q, won_d;

  logic [3:0]  overlap;
  logic [3:0]  cand;
  logic [3:0]  sel;

  hit_box u_hit_m1 (
    .ax      (bus.MissileX),
    .ay      (bus.MissileY),
    .bx      (bus.MonsterX),
    .by      (bus.MonsterY),
    .radius  (MON_R),
    .overlap (overlap[0])
  );

  hit_box u_hit_m2 (
    .ax      (bus.MissileX),
    .ay      (bus.MissileY),
    .bx      (bus.MonsterX2),
    .by      (bus.MonsterY2),
    .radius  (MON_R),
    .overlap (overlap[1])
  );

  hit_box u_hit_m3 (
    .ax      (bus.MissileX),
    .ay      (bus.MissileY),
    .bx      (bus.MonsterX3),
    .by      (bus.MonsterY3),
    .radius  (MON3_R),
    .overlap (overlap[2])
  );

  hit_box u_hit_boss (
    .ax      (bus.MissileX),
    .ay      (bus.MissileY),
    .bx      (bus.BossX),
    .by      (bus.BossY),
    .radius  (BOSS_R),
    .overlap (overlap[3])
  );

  // Level sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.keycode == START_KEY) state_d = StL1Init;
      StL1Init: state_d = StL1Play;
      StL1Play: if (dead_q[0] && dead_q[1]) state_d = StL2Init;
      StL2Init: state_d = StL2Play;
      StL2Play: if (dead_q[2]) state_d = StL3Init;
      StL3Init: state_d = StL3Play;
      StL3Play: if (dead_q[3]) state_d = StWon;
      StWon:    if (bus.keycode == START_KEY) state_d = StL1Init;
      default:  state_d = StIdle;
    endcase
  end

  // Only live enemies of the level being played can be hit, one per frame.
  always_comb begin
    cand[0] = (state_q == StL1Play) && !dead_q[0] && overlap[0];
    cand[1] = (state_q == StL1Play) && !dead_q[1] && overlap[1];
    cand[2] = (state_q == StL2Play) && !dead_q[2] && overlap[2];
    cand[3] = (state_q == StL3Play) && !dead_q[3] && overlap[3];
    if (!bus.missile_active) cand = '0;

    sel = '0;
    if (cand[0])      sel = 4'b0001;
    else if (cand[1]) sel = 4'b0010;
    else if (cand[2]) sel = 4'b0100;
    else if (cand[3]) sel = 4'b1000;
  end

  always_comb begin
    dead_d    = dead_q | {1'b0, sel[2:0]};
    boss_hp_d = boss_hp_q;
    hit_d     = |sel;

    if (sel[3]) begin
      boss_hp_d = boss_hp_q - 3'd1;
      if (boss_hp_q == 3'd1) dead_d[3] = 1'b1;
    end

    if (is_init(state_d)) begin
      dead_d    = '0;
      boss_hp_d = BossHpInit;
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    draw_d   = '0;
    motion_d = '0;
    won_d    = 1'b0;
    unique case (state_d)
      StL1Init: begin draw_d = 3'b001; motion_d = 3'b001; end
      StL1Play: draw_d = 3'b001;
      StL2Init: begin draw_d = 3'b010; motion_d = 3'b010; end
      StL2Play: draw_d = 3'b010;
      StL3Init: begin draw_d = 3'b100; motion_d = 3'b100; end
      StL3Play: draw_d = 3'b100;
      StWon:    won_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      dead_q    <= '0;
      boss_hp_q <= BossHpInit;
      hit_q     <= 1'b0;
      draw_q    <= '0;
      motion_q  <= '0;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dead_q    <= dead_d;
      boss_hp_q <= boss_hp_d;
      hit_q     <= hit_d;
      draw_q    <= draw_d;
      motion_q  <= motion_d;
      won_q     <= won_d;
    end
  end

  assign bus.is_dead      = dead_q[0];
  assign bus.is_dead2     = dead_q[1];
  assign bus.is_dead3     = dead_q[2];
  assign bus.boss_dead    = dead_q[3];
  assign bus.draw_level1  = draw_q[0];
  assign bus.draw_level2  = draw_q[1];
  assign bus.draw_level3  = draw_q[2];
  assign bus.set_motion_1 = motion_q[0];
  assign bus.set_motion_2 = motion_q[1];
  assign bus.set_motion_3 = motion_q[2];
  assign bus.missile_hit  = hit_q;
  assign bus.game_won     = won_q;

endmodule

// File: tb/tb_enemy_status_ctrl.sv
// Directed bench for enemy_status_ctrl: level flow, hit priority, boss HP and reset.
module tb_enemy_status_ctrl;
  import game_pkg::*;

  localparam logic [11:0] K_DEAD1 = 12'h800;
  localparam logic [11:0] K_DEAD2 = 12'h400;
  localparam logic [11:0] K_DEAD3 = 12'h200;
  localparam logic [11:0] K_BDEAD = 12'h100;
  localparam logic [11:0] K_DRAW1 = 12'h080;
  localparam logic [11:0] K_DRAW2 = 12'h040;
  localparam logic [11:0] K_DRAW3 = 12'h020;
  localparam logic [11:0] K_SM1   = 12'h010;
  localparam logic [11:0] K_SM2   = 12'h008;
  localparam logic [11:0] K_SM3   = 12'h004;
  localparam logic [11:0] K_HIT   = 12'h002;
  localparam logic [11:0] K_WON   = 12'h001;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   n_checks  = 0;
  int   n_fail    = 0;

  enemy_status_if bus ();

  enemy_status_ctrl dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus.slave)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [11:0] outs();
    return {bus.is_dead, bus.is_dead2, bus.is_dead3, bus.boss_dead,
            bus.draw_level1, bus.draw_level2, bus.draw_level3,
            bus.set_motion_1, bus.set_motion_2, bus.set_motion_3,
            bus.missile_hit, bus.game_won};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic set_missile(input logic act, input logic [9:0] x, input logic [9:0] y);
    bus.missile_active = act;
    bus.MissileX       = x;
    bus.MissileY       = y;
  endtask

  task automatic park_all();
    bus.MonsterX  = PARK_X; bus.MonsterY  = PARK_Y;
    bus.MonsterX2 = PARK_X; bus.MonsterY2 = PARK_Y;
    bus.MonsterX3 = PARK_X; bus.MonsterY3 = PARK_Y;
    bus.BossX     = PARK_X; bus.BossY     = PARK_Y;
  endtask

  initial begin
    bus.keycode = 8'h00;
    set_missile(1'b0, 10'd0, 10'd0);
    park_all();

    step();
    step();
    check_eq("reset_outs", 32'(outs()), 32'h0);
    check_eq("reset_hp", 32'(dut.boss_hp_q), 32'd5);
    Reset = 1'b0;

    step();
    check_eq("idle_no_key", 32'(outs()), 32'h0);

    bus.keycode = 8'h28;
    step();
    check_eq("l1_init", 32'(outs()), 32'(K_DRAW1 | K_SM1));
    step();
    check_eq("l1_play_key_ignored", 32'(outs()), 32'(K_DRAW1));
    bus.keycode = 8'h00;

    // Just outside the radius on X.
    bus.MonsterX = 10'd400; bus.MonsterY = 10'd200;
    set_missile(1'b1, 10'd426, 10'd200);
    step();
    check_eq("m1_miss_x26", 32'(outs()), 32'(K_DRAW1));

    // Missile overlaps both level-1 monsters; monster 1 wins first.
    bus.MonsterX2 = 10'd410; bus.MonsterY2 = 10'd200;
    set_missile(1'b1, 10'd405, 10'd200);
    step();
    check_eq("prio_m1", 32'(outs()), 32'(K_DRAW1 | K_DEAD1 | K_HIT));
    step();
    check_eq("prio_m2_next", 32'(outs()), 32'(K_DRAW1 | K_DEAD1 | K_DEAD2 | K_HIT));
    step();
    check_eq("l2_init", 32'(outs()), 32'(K_DRAW2 | K_SM2));
    step();
    check_eq("l2_play", 32'(outs()), 32'(K_DRAW2));

    bus.MonsterX3 = 10'd100; bus.MonsterY3 = 10'd100;
    set_missile(1'b0, 10'd100, 10'd100);
    step();
    check_eq("m3_inactive", 32'(outs()), 32'(K_DRAW2));
    set_missile(1'b1, 10'd116, 10'd100);
    step();
    check_eq("m3_miss_x16", 32'(outs()), 32'(K_DRAW2));
    set_missile(1'b1, 10'd115, 10'd85);
    step();
    check_eq("m3_hit_edge", 32'(outs()), 32'(K_DRAW2 | K_DEAD3 | K_HIT));
    step();
    check_eq("l3_init", 32'(outs()), 32'(K_DRAW3 | K_SM3));
    step();
    check_eq("l3_play", 32'(outs()), 32'(K_DRAW3));

    bus.BossX = 10'd320; bus.BossY = 10'd100;
    set_missile(1'b0, 10'd320, 10'd100);
    step();
    check_eq("boss_inactive", 32'(outs()), 32'(K_DRAW3));
    check_eq("boss_hp_held", 32'(dut.boss_hp_q), 32'd5);

    set_missile(1'b1, 10'd320, 10'd100);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_eq($sformatf("boss_hit%0d", i), 32'(outs()),
               32'(K_DRAW3 | K_HIT | ((i == 5) ? K_BDEAD : 12'h0)));
      check_eq($sformatf("boss_hp%0d", i), 32'(dut.boss_hp_q), 32'(5 - i));
    end
    step();
    check_eq("won", 32'(outs()), 32'(K_WON | K_BDEAD));

    bus.keycode = 8'h28;
    step();
    check_eq("restart_l1_init", 32'(outs()), 32'(K_DRAW1 | K_SM1));
    check_eq("restart_hp", 32'(dut.boss_hp_q), 32'd5);
    bus.keycode = 8'h00;
    step();
    check_eq("restart_l1_play", 32'(outs()), 32'(K_DRAW1));

    park_all();
    bus.MonsterX = 10'd400; bus.MonsterY = 10'd200;
    set_missile(1'b1, 10'd410, 10'd205);
    step();
    check_eq("m1_hit", 32'(outs()), 32'(K_DRAW1 | K_DEAD1 | K_HIT));
    step();
    check_eq("m1_no_rehit", 32'(outs()), 32'(K_DRAW1 | K_DEAD1));

    bus.MonsterX2 = 10'd200; bus.MonsterY2 = 10'd300;
    set_missile(1'b1, 10'd225, 10'd275);
    step();
    check_eq("m2_hit_edge", 32'(outs()), 32'(K_DRAW1 | K_DEAD1 | K_DEAD2 | K_HIT));
    step();
    check_eq("l2_init_again", 32'(outs()), 32'(K_DRAW2 | K_SM2));
    step();
    check_eq("l2_play_again", 32'(outs()), 32'(K_DRAW2));

    // Pending monster-3 hit is overridden by reset.
    bus.MonsterX3 = 10'd100; bus.MonsterY3 = 10'd100;
    set_missile(1'b1, 10'd100, 10'd100);
    Reset = 1'b1;
    step();
    check_eq("midlevel_reset", 32'(outs()), 32'h0);
    check_eq("midlevel_reset_hp", 32'(dut.boss_hp_q), 32'd5);
    Reset = 1'b0;
    step();
    check_eq("post_reset_idle", 32'(outs()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
